// File: rtl/ugemm_feed_pkg.sv
// Shared types and default sizing for the GEMM row-side feeder.
package ugemm_feed_pkg;

  localparam int DEF_HEIGHT  = 32'sd4;
  localparam int DEF_IWIDTH  = 32'sd16;
  localparam int DEF_CYCLE_W = 32'sd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } feed_state_t;

endpackage

// File: rtl/skew_delay.sv
// Synchronous-reset shift register of DEPTH stages; DEPTH=0 is a plain wire.
module skew_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_s;
      assign unused_s = clk ^ rst;
      assign q = d;
    end else begin : g_pipe
      logic [W-1:0] stage_r [DEPTH];

      // Shift the row word one stage per clock.
      always_ff @(posedge clk) begin
        if (rst) begin
          stage_r <= '{default: '0};
        end else begin
          stage_r[0] <= d;
          for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
          end
        end
      end

      assign q = stage_r[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/ifm_skew_feeder.sv
// Row-side feeder: holds each ifm vector for len_q MAC cycles and skews
// every row's data/enable/clear/done by its row index.
module ifm_skew_feeder
  import ugemm_feed_pkg::*;
#(
  parameter int HEIGHT  = DEF_HEIGHT,
  parameter int IWIDTH  = DEF_IWIDTH,
  parameter int CYCLE_W = DEF_CYCLE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CYCLE_W-1:0] cfg_cycles,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IWIDTH-1:0]  in_ifm [HEIGHT-1:0],
  input  logic               in_last,
  output logic [IWIDTH-1:0]  ifm [HEIGHT-1:0],
  output logic [HEIGHT-1:0]  en_i,
  output logic [HEIGHT-1:0]  clr_i,
  output logic [HEIGHT-1:0]  mac_done,
  output logic               busy
);

  localparam int RW = IWIDTH + 3;
  localparam logic [CYCLE_W-1:0] ONE        = CYCLE_W'(1);
  localparam logic [CYCLE_W-1:0] ZERO       = CYCLE_W'(0);
  localparam logic [CYCLE_W-1:0] DRAIN_LAST = CYCLE_W'((HEIGHT > 1) ? HEIGHT - 2 : 0);
  localparam bit                 HAS_DRAIN  = (HEIGHT > 1);

  feed_state_t        state_r, state_s;
  logic [CYCLE_W-1:0] cnt_r, cnt_s;
  logic [CYCLE_W-1:0] len_r, len_s;
  logic               last_r, last_s;
  logic [IWIDTH-1:0]  hold_r [HEIGHT-1:0];
  logic               en0_r, clr0_r, done0_r, ready_r, busy_r;
  logic               accept_s, final_s, final_next_s, load_s, clr_s;

  assign accept_s = in_valid & ready_r;
  assign final_s  = (cnt_r == len_r - ONE);

  // Next-state, counter and tile bookkeeping.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    len_s   = len_r;
    load_s  = 1'b0;
    clr_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = RUN;
          cnt_s   = ZERO;
          len_s   = (cfg_cycles == ZERO) ? ONE : cfg_cycles;
          load_s  = 1'b1;
          clr_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (!final_s) begin
          cnt_s = cnt_r + ONE;
        end else if (last_r) begin
          state_s = HAS_DRAIN ? DRAIN : IDLE;
          cnt_s   = ZERO;
        end else if (accept_s) begin
          cnt_s  = ZERO;
          load_s = 1'b1;
        end else begin
          state_s = GAP;
        end
      end
      GAP: begin
        if (accept_s) begin
          state_s = RUN;
          cnt_s   = ZERO;
          load_s  = 1'b1;
        end else begin
          state_s = GAP;
        end
      end
      DRAIN: begin
        if (cnt_r == DRAIN_LAST) begin
          state_s = IDLE;
          cnt_s   = ZERO;
        end else begin
          cnt_s = cnt_r + ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = ZERO;
      end
    endcase
    last_s       = load_s ? in_last : last_r;
    final_next_s = (cnt_s == len_s - ONE);
  end

  // Outputs are decoded from the next state so they align with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= ZERO;
      len_r   <= ZERO;
      last_r  <= 1'b0;
      hold_r  <= '{default: '0};
      en0_r   <= 1'b0;
      clr0_r  <= 1'b0;
      done0_r <= 1'b0;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      len_r   <= len_s;
      last_r  <= last_s;
      if (load_s) begin
        hold_r <= in_ifm;
      end else begin
        hold_r <= hold_r;
      end
      en0_r   <= (state_s == RUN);
      clr0_r  <= clr_s;
      done0_r <= (state_s == RUN) && final_next_s && last_s;
      ready_r <= (state_s == IDLE) || (state_s == GAP) ||
                 ((state_s == RUN) && final_next_s && !last_s);
      busy_r  <= (state_s != IDLE);
    end
  end

  assign in_ready = ready_r;
  assign busy     = busy_r;

  generate
    for (genvar h = 0; h < HEIGHT; h++) begin : g_row
      logic [RW-1:0] row_q_s;
      skew_delay #(.DEPTH(h), .W(RW)) u_skew (
        .clk (clk),
        .rst (rst),
        .d   ({hold_r[h], en0_r, clr0_r, done0_r}),
        .q   (row_q_s)
      );
      assign ifm[h]      = row_q_s[RW-1:3];
      assign en_i[h]     = row_q_s[2];
      assign clr_i[h]    = row_q_s[1];
      assign mac_done[h] = row_q_s[0];
    end
  endgenerate

endmodule

// File: tb/tb_ifm_skew_feeder.sv
// Self-checking bench for ifm_skew_feeder: tile-level reference model plus
// hand-computed timing pins for the directed scenarios.
module tb_ifm_skew_feeder;

  localparam int H  = 4;
  localparam int IW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] cfg;
  logic          in_valid, in_ready, in_last, busy;
  logic [IW-1:0] in_ifm [H-1:0];
  logic [IW-1:0] ifm [H-1:0];
  logic [H-1:0]  en_i, clr_i, mac_done;

  ifm_skew_feeder #(.HEIGHT(H), .IWIDTH(IW), .CYCLE_W(CW)) dut (
    .clk(clk), .rst(rst), .cfg_cycles(cfg), .in_valid(in_valid), .in_ready(in_ready),
    .in_ifm(in_ifm), .in_last(in_last), .ifm(ifm), .en_i(en_i), .clr_i(clr_i),
    .mac_done(mac_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (tile level) ----------------
  int            rem, drain, len;
  bit            tile_open, cur_last, e_ready, e_busy;
  logic [IW-1:0] vec [H-1:0];
  bit            h_en [H], h_clr [H], h_done [H];
  logic [IW-1:0] h_vec [H][H-1:0];

  always @(posedge clk) begin
    bit acc, c;
    if (rst) begin
      rem = 0; drain = 0; len = 0; tile_open = 0; cur_last = 0;
      e_ready = 0; e_busy = 0;
      for (int k = 0; k < H; k++) begin
        vec[k] = '0;
        h_en[k] = 0; h_clr[k] = 0; h_done[k] = 0;
        for (int j = 0; j < H; j++) h_vec[k][j] = '0;
      end
    end else begin
      acc = in_valid && e_ready;
      c = 0;
      if (drain > 0) drain--;
      if (rem > 0) begin
        rem--;
        if (rem == 0 && cur_last) begin
          tile_open = 0;
          drain = H - 1;
        end
      end
      if (acc) begin
        if (!tile_open) begin
          len = (cfg == 8'd0) ? 1 : int'(cfg);
          c = 1;
          tile_open = 1;
        end
        vec = in_ifm;
        cur_last = in_last;
        rem = len;
      end
      e_busy  = tile_open || (drain > 0);
      e_ready = (!tile_open && drain == 0) ||
                (tile_open && (rem == 0 || (rem == 1 && !cur_last)));
      for (int k = H - 1; k > 0; k--) begin
        h_en[k] = h_en[k-1]; h_clr[k] = h_clr[k-1]; h_done[k] = h_done[k-1];
        h_vec[k] = h_vec[k-1];
      end
      h_en[0]   = (rem > 0);
      h_clr[0]  = c;
      h_done[0] = (rem == 1) && cur_last;
      h_vec[0]  = vec;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  int en0_cnt = 0, clr0_cnt = 0, done0_cnt = 0;
  always @(negedge clk) begin
    if (chk_on) begin
      check("in_ready", 64'(in_ready), 64'(e_ready));
      check("busy", 64'(busy), 64'(e_busy));
      for (int h = 0; h < H; h++) begin
        check($sformatf("en_i[%0d]", h), 64'(en_i[h]), 64'(h_en[h]));
        check($sformatf("clr_i[%0d]", h), 64'(clr_i[h]), 64'(h_clr[h]));
        check($sformatf("mac_done[%0d]", h), 64'(mac_done[h]), 64'(h_done[h]));
        if (h_en[h]) check($sformatf("ifm[%0d]", h), 64'(ifm[h]), 64'(h_vec[h][h]));
      end
      en0_cnt   += int'(en_i[0]);
      clr0_cnt  += int'(clr_i[0]);
      done0_cnt += int'(mac_done[0]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [IW-1:0] base, input bit last);
    bit r;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_last  = last;
    for (int h = 0; h < H; h++) in_ifm[h] = base + IW'(h);
    do begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 200);
    if (!r) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready never seen after %0d cycles", n);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 200);
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles", n);
    end
    @(posedge clk);
    #1;
  endtask

  int e0, c0, d0;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; cfg = 8'd4;
    for (int h = 0; h < H; h++) in_ifm[h] = '0;
    @(posedge clk); #1;
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready_low", 64'(in_ready), 64'd0);
    check("rst_outputs", 64'({en_i, clr_i, mac_done, busy}), 64'd0);
    @(negedge clk);
    check("ready_after_release", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Single last vector {1,2,3,4}, len 4: pinned timing.
    cfg = 8'd4;
    send(16'd1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("s1_en0_k%0d", k), 64'(en_i[0]), 64'(k <= 3));
      check($sformatf("s1_en3_k%0d", k), 64'(en_i[3]), 64'(k >= 3 && k <= 6));
      check($sformatf("s1_busy_k%0d", k), 64'(busy), 64'(k < 7));
      for (int h = 0; h < H; h++) begin
        check($sformatf("s1_clr%0d_k%0d", h, k), 64'(clr_i[h]), 64'(k == h));
        check($sformatf("s1_done%0d_k%0d", h, k), 64'(mac_done[h]), 64'(k == 3 + h));
      end
      if (k == 0) check("s1_ifm0", 64'(ifm[0]), 64'd1);
      if (k == 3) check("s1_ifm3", 64'(ifm[3]), 64'd4);
    end
    @(posedge clk); #1;

    // Three back-to-back vectors, len 2.
    cfg = 8'd2;
    e0 = en0_cnt; c0 = clr0_cnt; d0 = done0_cnt;
    send(16'h10, 1'b0);
    send(16'h20, 1'b0);
    send(16'h30, 1'b1);
    wait_idle();
    check("b2b_en0_cycles", 64'(en0_cnt - e0), 64'd6);
    check("b2b_clr0", 64'(clr0_cnt - c0), 64'd1);
    check("b2b_done0", 64'(done0_cnt - d0), 64'd1);

    // Bubble: second vector offered late.
    e0 = en0_cnt; c0 = clr0_cnt;
    send(16'h40, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    send(16'h50, 1'b1);
    wait_idle();
    check("bubble_en0_cycles", 64'(en0_cnt - e0), 64'd4);
    check("bubble_clr0", 64'(clr0_cnt - c0), 64'd1);

    // cfg 0 and cfg 1 both hold a single cycle; clr and done coincide.
    for (int c = 0; c < 2; c++) begin
      cfg = CW'(c);
      send(16'h60, 1'b1);
      @(negedge clk);
      check("len1_row0", 64'({en_i[0], clr_i[0], mac_done[0]}), 64'd7);
      @(negedge clk);
      check("len1_row1", 64'({en_i[1], clr_i[1], mac_done[1]}), 64'd7);
      check("len1_en0_off", 64'(en_i[0]), 64'd0);
      wait_idle();
    end

    // cfg change mid-tile is ignored until the next tile.
    cfg = 8'd4;
    e0 = en0_cnt;
    send(16'h70, 1'b0);
    cfg = 8'd7;
    send(16'h80, 1'b1);
    wait_idle();
    check("cfg_change_en0_cycles", 64'(en0_cnt - e0), 64'd8);

    // Reset during RUN with cnt=2.
    cfg = 8'd4;
    d0 = done0_cnt;
    send(16'h90, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_outputs", 64'({en_i, clr_i, mac_done, busy, in_ready}), 64'd0);
    @(negedge clk);
    check("midrst_ready", 64'(in_ready), 64'd1);
    repeat (8) @(negedge clk);
    check("midrst_no_done", 64'(done0_cnt - d0), 64'd0);
    @(posedge clk); #1;

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      cfg = CW'($urandom_range(0, 5));
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end
      repeat ($urandom_range(0, 2) == 0 ? $urandom_range(1, 3) : 0) @(posedge clk);
      #1;
      send(IW'($urandom), $urandom_range(0, 3) == 0);
    end
    send(16'hA0, 1'b1);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifm_skew_feeder.md
# ifm_skew_feeder

Row-side feeder for the unary rate-coded GEMM systolic array. It accepts one HEIGHT-wide ifm vector per handshake and holds it for a programmable number of MAC cycles. It generates per-row `en_i`/`clr_i`/`mac_done` and skews every row signal by its row index, so row h enters the array h cycles after row 0. It sits directly upstream of the array's row inputs (`ifm`, `en_i`, `clr_i`, `mac_done`).

## Interface
Parameters:
- `HEIGHT`, 4: array rows driven.
- `IWIDTH`, 16: ifm element width.
- `CYCLE_W`, 8: width of the MAC-cycle count.

Ports:
- `clk`  in  1  sole clock; everything is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_cycles`  in  CYCLE_W  cycles each vector is held (unary bitstream length); 0 is treated as 1.
- `in_valid`  in  1  upstream vector valid.
- `in_ready`  out  1  feeder accepts the vector this cycle.
- `in_ifm`  in  IWIDTH×HEIGHT (unpacked [HEIGHT-1:0])  vector, element h goes to row h.
- `in_last`  in  1  marks the final vector of a tile (accumulation window).
- `ifm`  out  IWIDTH×HEIGHT  skewed row data to the array.
- `en_i`  out  HEIGHT  per-row enable, skewed.
- `clr_i`  out  HEIGHT  per-row clear, skewed.
- `mac_done`  out  HEIGHT  per-row end-of-tile pulse, skewed.
- `busy`  out  1  state is not IDLE.

## Operation
- Row-0 signals come from the FSM and a hold register. Row h is row 0 delayed by h registers (data and all three controls). The delay line for row 0 is zero-length.
- FSM states:
  - IDLE: `in_ready`=1. On accept, go to RUN and latch `cfg_cycles` into `len_q`. This is a tile start.
  - RUN: hold vector. Counter `cnt` runs 0..len_q-1. Row-0 `en_i`=1 every cycle.
  - GAP: the tile is open but no vector is held. `in_ready`=1. Row-0 `en_i`=0.
  - DRAIN: HEIGHT-1 cycles with `in_ready`=0 while the skew flushes. Then go to IDLE.
- RUN transitions are evaluated on the final cycle (cnt==len_q-1):
  - Current vector had `in_last`: go to DRAIN.
  - Otherwise, `in_valid`=1: accept back-to-back and stay in RUN with cnt=0.
  - Otherwise: go to GAP.
- GAP transitions: accept → RUN. No clear is issued, and `len_q` is unchanged.
- `in_ready`=1 only in IDLE, in GAP, and on the final RUN cycle of a vector not marked last.
- Row-0 `clr_i`=1 only on the first RUN cycle of a tile, i.e. the vector accepted from IDLE.
- Row-0 `mac_done`=1 only on the final RUN cycle of the `in_last` vector.
- A vector accepted with `in_last` from IDLE gives a single-vector tile: `clr_i` and `mac_done` both pulse, coincident when len=1.
- `len_q` is sampled only at tile start. A `cfg_cycles` change mid-tile is ignored.
- Row-0 `ifm` holds the latched vector during RUN. It holds its last value in GAP/IDLE and is only meaningful while `en_i`=1.
- `cnt` is CYCLE_W bits and never wraps, since len_q ≤ 2^CYCLE_W-1.

## Timing
- Reset: while `rst` is high and the cycle after, all outputs are 0, including `in_ready` and `busy`. All delay registers are 0 and the FSM is in IDLE.
- Latency: vector accepted at edge t → row-0 `en_i` high on cycles t+1..t+len. Row h is high on t+1+h..t+len+h.
- Back-to-back vectors give an unbroken `en_i` on every row. There is no bubble between vectors.
- `busy` falls HEIGHT-1 cycles after the last row-0 `en_i`. On that cycle, row HEIGHT-1 shows its final `en_i`/`mac_done`.
- Reset asserted mid-tile clears all state on the same edge. No partial `mac_done` is emitted afterward.
- `in_valid` may drop at any time. There is no combinational path from `in_valid` to `in_ready`.

## Structure
- Package `ugemm_feed_pkg`: FSM state enum `feed_state_t` {IDLE, RUN, GAP, DRAIN} and the default parameter constants.
- Sub-module `skew_delay` (parameters DEPTH, W) is a synchronous-reset shift register. It is instantiated per row with DEPTH=h, plus a pass-through for DEPTH=0.
- The FSM and counter live in the top module. Expected size is roughly 200 lines.

## Test plan
- cfg_cycles=4, one vector {1,2,3,4} with in_last, accepted at t0 → row0 `en_i` t0+1..t0+4; row3 t0+4..t0+7; `clr_i` row h at t0+1+h; `mac_done` row h at t0+4+h; `busy` low at t0+8.
- cfg_cycles=2, three back-to-back vectors, last flagged → `en_i` row0 continuous for 6 cycles; only one `clr_i` and one `mac_done` per row; `in_ready` high exactly at accept cycles.
- Bubble: second vector offered 3 cycles late → GAP entered; row0 `en_i` gap of 3 cycles; no second `clr_i`.
- cfg_cycles=0 and cfg_cycles=1 → both hold one cycle; a single-vector tile has `clr_i` and `mac_done` coincident per row.
- `cfg_cycles` changed 4→7 mid-tile → hold stays 4 until the next tile start.
- `rst` pulsed during RUN with cnt=2 → next cycle all outputs 0, IDLE, `in_ready`=1 one cycle after release; no stale `mac_done` on any row.
